// File: rtl/fsm_pkg.sv
// Shared types and constants for the word serializer and the 11011 detector benches.
package fsm_pkg;

   // Serializer control states: waiting for a word, or shifting one out.
   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } ser_state_t;

   // Default number of bits per parallel word.
   localparam int DEFAULT_WIDTH = 8;

   // Sequence the downstream Moore/Mealy detectors look for.
   localparam logic [4:0] PATTERN_11011 = 5'b11011;

   // Bit selected onto the serial line from a shift register image.
   function automatic logic pick_bit(input logic msb_bit, input logic lsb_bit, input bit msb_first);
      logic b;
      if (msb_first) begin
         b = msb_bit;
      end else begin
         b = lsb_bit;
      end
      return b;
   endfunction

endpackage

// File: rtl/word_hold_buf.sv
// One-entry word buffer with a full flag. A load fills it, a take empties it.
// The serializer only loads when empty and only takes when full, so both never coincide.
module word_hold_buf
   import fsm_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             take,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             full_q, full_d;

   // Next buffer contents: capture on load, release on take, otherwise keep.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (load) begin
         data_d = din;
         full_d = 1'b1;
      end else if (take) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   // Buffer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign dout = data_q;
   assign full = full_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end feeding the 11011 detectors one bit per clock.
// A one-word hold buffer lets the next word start on the edge that ends the
// current one, so the serial stream has no gap between back-to-back words.
module word_serializer
   import fsm_pkg::*;
#(
   parameter int   WIDTH     = DEFAULT_WIDTH,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0,
   parameter int   CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_done,
   output logic [CNT_W-1:0] words_sent
);

   localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] words_q, words_d;

   logic             hold_full_s;
   logic [WIDTH-1:0] hold_data_s;
   logic             hold_load_s;
   logic             hold_take_s;
   logic             accept_s;
   logic             last_s;

   word_hold_buf #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk  (clk),
      .rst  (rst),
      .load (hold_load_s),
      .take (hold_take_s),
      .din  (data_in),
      .dout (hold_data_s),
      .full (hold_full_s)
   );

   // Handshake and last-bit decode; ready comes only from the registered hold flag.
   always_comb begin
      accept_s = data_valid & ~hold_full_s;
      last_s   = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
   end

   // Next-state logic: load, shift, hand over from hold or new word, count words.
   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      words_d     = words_q;
      hold_load_s = 1'b0;
      hold_take_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               sreg_d  = data_in;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (last_s) begin
               words_d = words_q + CNT_W'(1);
               cnt_d   = '0;
               if (hold_full_s) begin
                  sreg_d      = hold_data_s;
                  hold_take_s = 1'b1;
               end else if (accept_s) begin
                  sreg_d = data_in;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d       = cnt_q + CW'(1);
               hold_load_s = accept_s;
               if (MSB_FIRST != 0) begin
                  sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
               end else begin
                  sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, shift register, bit counter and word counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         words_q <= words_d;
      end
   end

   // Outputs derived only from registers, so no input reaches them combinationally.
   always_comb begin
      data_ready = ~hold_full_s;
      ser_valid  = (state_q == S_SHIFT);
      frame_done = last_s;
      words_sent = words_q;
      if (state_q == S_SHIFT) begin
         ser_out = pick_bit(sreg_q[WIDTH-1], sreg_q[0], (MSB_FIRST != 0));
      end else begin
         ser_out = IDLE_BIT;
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: one MSB-first instance (16-bit counter) and one
// LSB-first instance (2-bit counter). Expected serial bits go into a queue per
// instance when a word is offered; monitors pop and compare on every data bit.
module tb_word_serializer;
   import fsm_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din_a, din_b;
   logic       dv_a, dv_b;
   logic       rdy_a, rdy_b, so_a, so_b, sv_a, sv_b, fd_a, fd_b;
   logic [15:0] ws_a;
   logic [1:0]  ws_b;

   always #5 clk = ~clk;

   word_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .data_in(din_a), .data_valid(dv_a), .data_ready(rdy_a),
      .ser_out(so_a), .ser_valid(sv_a), .frame_done(fd_a), .words_sent(ws_a));

   word_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .data_in(din_b), .data_valid(dv_b), .data_ready(rdy_b),
      .ser_out(so_b), .ser_valid(sv_b), .frame_done(fd_b), .words_sent(ws_b));

   typedef struct packed {
      logic b;
      logic last;
   } exp_bit_t;

   typedef struct packed {
      logic       sel;    // 0: MSB-first instance, 1: LSB-first instance
      logic [7:0] word;
      logic [7:0] exp;    // expected serial stream, exp[7] is the first bit out
   } vec_t;

   exp_bit_t qa[$];
   exp_bit_t qb[$];
   int total = 0;
   int bad = 0;
   bit mon_en = 1'b0;
   int run_a = 0;
   int last_run_a = 0;
   int exp_ws_a = 0;
   int exp_ws_b = 0;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor for the MSB-first instance, sampled mid-cycle.
   always @(negedge clk) begin
      exp_bit_t e;
      if (mon_en) begin
         if (sv_a) begin
            run_a++;
            if (qa.size() == 0) begin
               chk("a_unexpected_bit", 32'd1, 32'd0);
            end else begin
               e = qa.pop_front();
               chk("a_ser_out", 32'(so_a), 32'(e.b));
               chk("a_frame_done", 32'(fd_a), 32'(e.last));
            end
         end else begin
            if (run_a != 0) last_run_a = run_a;
            run_a = 0;
            chk("a_idle_lines", 32'({so_a, fd_a}), 32'd0);
         end
      end
   end

   // Scoreboard monitor for the LSB-first instance.
   always @(negedge clk) begin
      exp_bit_t e;
      if (mon_en) begin
         if (sv_b) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_bit", 32'd1, 32'd0);
            end else begin
               e = qb.pop_front();
               chk("b_ser_out", 32'(so_b), 32'(e.b));
               chk("b_frame_done", 32'(fd_b), 32'(e.last));
            end
         end else begin
            chk("b_idle_lines", 32'({so_b, fd_b}), 32'd0);
         end
      end
   end

   // Offer one word, queue its expected bits, hold valid until accepted.
   task automatic send(input logic sel, input logic [7:0] word, input logic [7:0] exp,
                       output int waited);
      for (int i = 0; i < 8; i++) begin
         if (sel) qb.push_back('{b: exp[7-i], last: (i == 7)});
         else     qa.push_back('{b: exp[7-i], last: (i == 7)});
      end
      waited = 0;
      if (sel) begin
         din_b = word; dv_b = 1'b1;
         while (!rdy_b && waited < 50) begin @(posedge clk); #1; waited++; end
      end else begin
         din_a = word; dv_a = 1'b1;
         while (!rdy_a && waited < 50) begin @(posedge clk); #1; waited++; end
      end
      if (waited >= 50) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      if (sel) begin dv_b = 1'b0; din_b = 8'h00; end
      else     begin dv_a = 1'b0; din_a = 8'h00; end
   endtask

   // Wait until all queued bits are out and the instance is idle again.
   task automatic wait_idle(input logic sel);
      int n;
      n = 0;
      while ((sel ? (qb.size() != 0 || sv_b) : (qa.size() != 0 || sv_a)) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      vecs[0] = '{sel: 1'b0, word: 8'hDB, exp: 8'b1101_1011};
      vecs[1] = '{sel: 1'b0, word: 8'h00, exp: 8'b0000_0000};
      vecs[2] = '{sel: 1'b0, word: 8'hFF, exp: 8'b1111_1111};
      vecs[3] = '{sel: 1'b0, word: 8'h5A, exp: 8'b0101_1010};
      vecs[4] = '{sel: 1'b1, word: 8'h1B, exp: 8'b1101_1000};
      vecs[5] = '{sel: 1'b1, word: 8'h01, exp: 8'b1000_0000};
      vecs[6] = '{sel: 1'b1, word: 8'h80, exp: 8'b0000_0001};
      vecs[7] = '{sel: 1'b1, word: 8'hC1, exp: 8'b1000_0011};
      vecs[8] = '{sel: 1'b1, word: 8'h36, exp: 8'b0110_1100};

      // Reset held for two edges while words are offered.
      rst = 1'b0;
      din_a = 8'hFF; din_b = 8'hFF; dv_a = 1'b1; dv_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_ser_out", 32'(so_a), 32'd0);
      chk("rst_a_ser_valid", 32'(sv_a), 32'd0);
      chk("rst_a_ready", 32'(rdy_a), 32'd1);
      chk("rst_a_words", 32'(ws_a), 32'd0);
      chk("rst_b_ser_valid", 32'(sv_b), 32'd0);
      chk("rst_b_words", 32'(ws_b), 32'd0);
      dv_a = 1'b0; dv_b = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_no_accept_a", 32'(sv_a), 32'd0);
      chk("rst_no_accept_b", 32'(sv_b), 32'd0);
      mon_en = 1'b1;

      // Table-driven single words on both instances.
      for (int i = 0; i < 9; i++) begin
         send(vecs[i].sel, vecs[i].word, vecs[i].exp, w);
         wait_idle(vecs[i].sel);
         if (vecs[i].sel) begin
            exp_ws_b++;
            chk("b_words_sent", 32'(ws_b), 32'(exp_ws_b % 4));
         end else begin
            exp_ws_a++;
            chk("a_words_sent", 32'(ws_a), 32'(exp_ws_a));
         end
      end
      chk("b_words_wrap", 32'(ws_b), 32'd1);

      // Back-to-back words: gapless stream, hold blocks ready.
      send(1'b0, 8'h1B, 8'b0001_1011, w);
      send(1'b0, 8'h60, 8'b0110_0000, w);
      chk("b2b_ready_low", 32'(rdy_a), 32'd0);
      wait_idle(1'b0);
      @(negedge clk); #1;
      chk("b2b_run_len", 32'(last_run_a), 32'd16);
      exp_ws_a += 2;
      chk("b2b_words", 32'(ws_a), 32'(exp_ws_a));

      // Three words offered continuously: third waits for the hold to drain.
      send(1'b0, 8'hA5, 8'b1010_0101, w);
      send(1'b0, 8'h3C, 8'b0011_1100, w);
      send(1'b0, 8'hC3, 8'b1100_0011, w);
      chk("bp_wait_cycles", 32'(w), 32'd7);
      wait_idle(1'b0);
      @(negedge clk); #1;
      chk("bp_run_len", 32'(last_run_a), 32'd24);
      exp_ws_a += 3;
      chk("bp_words", 32'(ws_a), 32'(exp_ws_a));

      // Reset during bit 4 of a word with a second word held.
      send(1'b0, 8'hFF, 8'b1111_1111, w);
      send(1'b0, 8'h0F, 8'b0000_1111, w);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      qa.delete();
      exp_ws_a = 0;
      chk("mid_rst_ser_out", 32'(so_a), 32'd0);
      chk("mid_rst_ser_valid", 32'(sv_a), 32'd0);
      chk("mid_rst_ready", 32'(rdy_a), 32'd1);
      chk("mid_rst_words", 32'(ws_a), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("mid_rst_dropped", 32'(sv_a), 32'd0);
      chk("mid_rst_words_after", 32'(ws_a), 32'(exp_ws_a));

      // Fresh word after the reset restarts cleanly.
      send(1'b0, 8'h96, 8'b1001_0110, w);
      wait_idle(1'b0);
      exp_ws_a++;
      chk("post_rst_words", 32'(ws_a), 32'(exp_ws_a));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
